// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data memory controller: funct3 encodings,
// FSM states and error causes.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_FUNCT3   = 2'd1;
  localparam logic [1:0] ERR_MISALIGN = 2'd2;
  localparam logic [1:0] ERR_RANGE    = 2'd3;

  // Stores have no unsigned variants, so BU/HU are only legal for loads.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/data_mem_ctrl_lsu_align.sv
// Byte-lane steering for RISC-V loads/stores: byte enables, store data
// replication, load extraction with sign/zero extension, misalignment flag.
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword[{addr_lo, 3'b000} +: 8];
  assign rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    be        = '0;
    wdata_sh  = wdata;
    rdata_ext = '0;
    misalign  = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_lo;
        wdata_sh  = {4{wdata[7:0]}};
        rdata_ext = funct3[2] ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      end
      2'b01: begin
        misalign  = addr_lo[0];
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh  = {2{wdata[15:0]}};
        rdata_ext = funct3[2] ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
      end
      2'b10: begin
        misalign  = (addr_lo != 2'b00);
        be        = 4'b1111;
        rdata_ext = rword;
      end
      default: begin
        be        = '0;
        rdata_ext = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Handshaked RISC-V data memory: owns the word array, sequences each request
// through optional wait states, and returns one response strobe per request.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [2:0]  lat_f3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  logic [32:0]   offset;
  logic [AW-1:0] widx;
  logic [31:0]   rword;
  logic [3:0]    be;
  logic [31:0]   wdata_sh;
  logic [31:0]   rdata_ext;
  logic          misalign;
  logic          out_of_range;
  logic [1:0]    err_cause;
  logic          err;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Offset is taken in 33 bits so an address below BASE_ADDR shows up as a
  // set sign bit rather than wrapping into the array.
  assign offset       = {1'b0, lat_addr} - {1'b0, BASE_ADDR};
  assign out_of_range = offset[32] || (offset >= SPAN);
  assign widx         = offset[AW+1:2];
  assign rword        = mem[widx];

  lsu_align u_align (
    .funct3    (lat_f3),
    .addr_lo   (lat_addr[1:0]),
    .wdata     (lat_wdata),
    .rword     (rword),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext),
    .misalign  (misalign)
  );

  always_comb begin
    err_cause = ERR_NONE;
    if (!funct3_legal(lat_we, lat_f3)) err_cause = ERR_FUNCT3;
    else if (misalign)                 err_cause = ERR_MISALIGN;
    else if (out_of_range)             err_cause = ERR_RANGE;
  end

  assign err = (err_cause != ERR_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_f3    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_f3    <= req_funct3;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            if (WAIT_STATES > 0) begin
              cnt   <= CNT_INIT;
              state <= WAIT;
            end else begin
              state <= ACCESS;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= ACCESS;
          else             cnt   <= cnt - 4'd1;
        end
        ACCESS: begin
          rsp_valid <= 1'b1;
          rsp_err   <= err;
          rsp_rdata <= (err || lat_we) ? '0 : rdata_ext;
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array is not reset; a reset during ACCESS forces state to IDLE first,
  // so an in-flight store is never committed.
  always_ff @(posedge clk) begin
    if (state == ACCESS && lat_we && !err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench: one zero-wait-state and one three-wait-state
// controller sharing clock, reset and request fields.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v0 = 1'b0, v3 = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;

  logic        rdy0, rv0, er0, busy0;
  logic [31:0] rd0;
  logic        rdy3, rv3, er3, busy3;
  logic [31:0] rd3;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(rdy0), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(er0), .busy(busy0));

  data_mem_ctrl #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rdy3), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(er3), .busy(busy3));

  // Issue one request and return its response and latency in edges after the handshake edge.
  task automatic do_req(input bit sel, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    if (sel) v3 = 1'b1; else v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0; v3 = 1'b0;
    lat = 0; rd = '0; er = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (sel ? rv3 : rv0) begin
        lat = c; rd = sel ? rd3 : rd0; er = sel ? er3 : er0;
        break;
      end
    end
    if (lat == 0) begin
      tests_run++; tests_failed++;
      $display("FAIL rsp_timeout addr=%h got no rsp_valid within 40 cycles", addr);
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests_run++;
    if ({rv0, er0, rd0, busy0} !== 35'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got v=%b e=%b d=%h b=%b want all 0", rv0, er0, rd0, busy0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({rdy0, rdy3, busy0, busy3, rv3} !== 5'b11000) begin
      tests_failed++;
      $display("FAIL reset_ready got %b want 11000", {rdy0, rdy3, busy0, busy3, rv3});
    end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    do_req(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
    tests_run++;
    if ({er, rd, lat} !== {1'b0, 32'h0, 32'd1}) begin
      tests_failed++;
      $display("FAIL sw_rsp got e=%b d=%h lat=%0d want e=0 d=0 lat=1", er, rd, lat);
    end
    do_req(0, 0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    tests_run++;
    if ({er, rd, lat} !== {1'b0, 32'hDEADBEEF, 32'd1}) begin
      tests_failed++;
      $display("FAIL lw_rsp got e=%b d=%h lat=%0d want e=0 d=deadbeef lat=1", er, rd, lat);
    end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat;
    logic [2:0]  f3s [3] = '{3'b000, 3'b100, 3'b010};
    logic [31:0] ads [3] = '{32'h21, 32'h21, 32'h20};
    logic [31:0] exp [3] = '{32'hFFFFFF80, 32'h00000080, 32'h00008000};
    do_req(0, 1, 3'b000, 32'h21, 32'h00000080, rd, er, lat);
    for (int i = 0; i < 3; i++) begin
      do_req(0, 0, f3s[i], ads[i], 32'h0, rd, er, lat);
      tests_run++;
      if ({er, rd} !== {1'b0, exp[i]}) begin
        tests_failed++;
        $display("FAIL byte_load%0d got e=%b d=%h want e=0 d=%h", i, er, rd, exp[i]);
      end
    end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lat;
    logic [2:0]  f3s [4] = '{3'b001, 3'b101, 3'b010, 3'b001};
    logic [31:0] ads [4] = '{32'h42, 32'h42, 32'h40, 32'h40};
    logic [31:0] exp [4] = '{32'h00001234, 32'h00001234, 32'h12348001, 32'hFFFF8001};
    do_req(0, 1, 3'b001, 32'h42, 32'hAAAA1234, rd, er, lat);
    do_req(0, 1, 3'b001, 32'h40, 32'h00008001, rd, er, lat);
    for (int i = 0; i < 4; i++) begin
      do_req(0, 0, f3s[i], ads[i], 32'h0, rd, er, lat);
      tests_run++;
      if ({er, rd} !== {1'b0, exp[i]}) begin
        tests_failed++;
        $display("FAIL half_load%0d got e=%b d=%h want e=0 d=%h", i, er, rd, exp[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    logic        wes [6] = '{0, 1, 0, 0, 1, 1};
    logic [2:0]  f3s [6] = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b100, 3'b010};
    logic [31:0] ads [6] = '{32'h13, 32'h45, 32'h10, 32'h1000, 32'h44, 32'h46};
    do_req(0, 1, 3'b010, 32'h44, 32'hAABBCCDD, rd, er, lat);
    for (int i = 0; i < 6; i++) begin
      do_req(0, wes[i], f3s[i], ads[i], 32'hFFFFFFFF, rd, er, lat);
      tests_run++;
      if ({er, rd} !== {1'b1, 32'h0}) begin
        tests_failed++;
        $display("FAIL err_case%0d got e=%b d=%h want e=1 d=0", i, er, rd);
      end
    end
    do_req(0, 0, 3'b010, 32'h44, 32'h0, rd, er, lat);
    tests_run++;
    if ({er, rd} !== {1'b0, 32'hAABBCCDD}) begin
      tests_failed++;
      $display("FAIL err_nowrite got e=%b d=%h want e=0 d=aabbccdd", er, rd);
    end
    do_req(0, 1, 3'b000, 32'hFFF, 32'h0000005A, rd, er, lat);
    do_req(0, 0, 3'b100, 32'hFFF, 32'h0, rd, er, lat);
    tests_run++;
    if ({er, rd} !== {1'b0, 32'h5A}) begin
      tests_failed++;
      $display("FAIL last_byte got e=%b d=%h want e=0 d=0000005a", er, rd);
    end
    do_req(0, 0, 3'b010, 32'hFFC, 32'h0, rd, er, lat);
    tests_run++;
    if ({er, rd} !== {1'b0, 32'h5A000000}) begin
      tests_failed++;
      $display("FAIL last_word got e=%b d=%h want e=0 d=5a000000", er, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat;
    do_req(0, 1, 3'b010, 32'h30, 32'h11223344, rd, er, lat);
    do_req(0, 0, 3'b010, 32'h30, 32'h0, rd, er, lat);
    tests_run++;
    if ({er, rd} !== {1'b0, 32'h11223344}) begin
      tests_failed++;
      $display("FAIL raw_b2b got e=%b d=%h want e=0 d=11223344", er, rd);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int lat;
    int edge_n, hs1, hs2, bad;
    logic hs;
    do_req(1, 1, 3'b010, 32'h50, 32'hCAFEF00D, rd, er, lat);
    tests_run++;
    if ({er, lat} !== {1'b0, 32'd4}) begin
      tests_failed++;
      $display("FAIL ws_sw_latency got e=%b lat=%0d want e=0 lat=4", er, lat);
    end
    // Hold req_valid across two requests and measure handshake spacing.
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h50; req_wdata = '0;
    v3 = 1'b1;
    hs1 = -1; hs2 = -1; bad = 0;
    for (edge_n = 0; edge_n < 30 && hs2 < 0; edge_n++) begin
      hs = rdy3;
      @(posedge clk); #1;
      if (hs) begin
        if (hs1 < 0) hs1 = edge_n; else hs2 = edge_n;
      end
      if (hs2 < 0 && (rdy3 !== ~busy3)) bad++;
      if (hs1 >= 0 && hs2 < 0 && rv3 !== 1'b1 && (rdy3 !== 1'b0 && edge_n - hs1 < 5)) bad++;
    end
    v3 = 1'b0;
    tests_run++;
    if (hs2 - hs1 !== 6 || hs1 < 0) begin
      tests_failed++;
      $display("FAIL ws_held_valid got spacing=%0d want 6", hs2 - hs1);
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL ws_ready_busy got %0d bad cycles want 0", bad);
    end
    for (int c = 0; c < 20 && busy3; c++) @(posedge clk);
    #1;
    tests_run++;
    if ({busy3, rd3} !== {1'b0, 32'hCAFEF00D}) begin
      tests_failed++;
      $display("FAIL ws_lw got b=%b d=%h want b=0 d=cafef00d", busy3, rd3);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int lat;
    logic seen;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h8; req_wdata = 32'h55;
    v3 = 1'b1;
    @(posedge clk); #1;
    v3 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({rv3, er3, rd3, busy3} !== 35'd0) begin
      tests_failed++;
      $display("FAIL abort_outputs got v=%b e=%b d=%h b=%b want all 0", rv3, er3, rd3, busy3);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (rv3) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_rsp got rsp_valid=1 want 0");
    end
    do_req(1, 0, 3'b010, 32'h8, 32'h0, rd, er, lat);
    tests_run++;
    if ({er, rd, lat} !== {1'b0, 32'h0, 32'd4}) begin
      tests_failed++;
      $display("FAIL abort_dropped got e=%b d=%h lat=%0d want e=0 d=0 lat=4", er, rd, lat);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_wait_states();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation exceeded 200us");
    $fatal(1);
  end

endmodule
